axi_lite_slave_regs: RTL and testbench

- AXI4-Lite responder exposing a bank of 32-bit memory-mapped registers to an AXI4-Lite initiator, such as the CPU-side bus bridge.
- Five independent channels (AW, W, B, AR, R); write and read paths run concurrently.
- Register contents drive fabric logic through a flat output vector; intended as the standard peripheral endpoint on the MCU interconnect.

---
 rtl/axi_lite_pkg.sv | 8 +
 rtl/axi_lite_strb_merge.sv | 13 +
 rtl/axi_lite_slave_regs.sv | 133 +++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response codes, FSM state types and bus widths
package axi_lite_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
endpackage

// File: rtl/axi_lite_strb_merge.sv
// axi_lite_strb_merge: byte-masked merge of old register data with write data
module axi_lite_strb_merge
  import axi_lite_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] oldData,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic [STRB_WIDTH-1:0] wStrb,
  output logic [DATA_WIDTH-1:0] newData
);
  for (genvar i = 0; i < STRB_WIDTH; i++) begin : gByte
    assign newData[8*i +: 8] = wStrb[i] ? wData[8*i +: 8] : oldData[8*i +: 8];
  end
endmodule

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI4-Lite register bank with independent write/read FSMs
// Optional AXIL_ADDR_DECODE_ERR_EN: nonzero high address bits give SLVERR instead of aliasing
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    AWADDR,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [DATA_WIDTH-1:0]    WDATA,
  input  logic [STRB_WIDTH-1:0]    WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [ADDR_WIDTH-1:0]    ARADDR,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [DATA_WIDTH-1:0]    RDATA,
  output logic [1:0]               RRESP,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [NUM_REGS*32-1:0]   regOut
);
  localparam int IDX_W = $clog2(NUM_REGS);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  wstate_t wState;
  rstate_t rState;
  logic awCaptured, wCaptured, awHs, wHs, aHave, dHave, commit, wErr, rErr;
  logic [ADDR_WIDTH-1:0] awAddrQ, awAddrEff;
  logic [DATA_WIDTH-1:0] wDataQ, wDataEff, mergeData;
  logic [STRB_WIDTH-1:0] wStrbQ, wStrbEff;
  logic [IDX_W-1:0] wIdx, rIdx;
  logic unusedAddrBits;
  assign awHs      = AWVALID && AWREADY;
  assign wHs       = WVALID && WREADY;
  assign aHave     = awCaptured || awHs;
  assign dHave     = wCaptured || wHs;
  assign commit    = (wState == W_IDLE) && aHave && dHave;
  // A same-edge handshake bypasses the holding registers so the write commits immediately
  assign awAddrEff = awCaptured ? awAddrQ : AWADDR;
  assign wDataEff  = wCaptured ? wDataQ : WDATA;
  assign wStrbEff  = wCaptured ? wStrbQ : WSTRB;
  assign wIdx      = awAddrEff[IDX_W+1:2];
  assign rIdx      = ARADDR[IDX_W+1:2];
  assign unusedAddrBits = ^{awAddrEff, ARADDR};
`ifdef AXIL_ADDR_DECODE_ERR_EN
  assign wErr = (awAddrEff >> (IDX_W + 2)) != '0;
  assign rErr = (ARADDR >> (IDX_W + 2)) != '0;
`else
  assign wErr = 1'b0;
  assign rErr = 1'b0;
`endif
  axi_lite_strb_merge uMerge (
    .oldData(regs[wIdx]),
    .wData  (wDataEff),
    .wStrb  (wStrbEff),
    .newData(mergeData)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wState     <= W_IDLE;
      awCaptured <= 1'b0;
      wCaptured  <= 1'b0;
      awAddrQ    <= '0;
      wDataQ     <= '0;
      wStrbQ     <= '0;
      AWREADY    <= 1'b0;
      WREADY     <= 1'b0;
      BVALID     <= 1'b0;
      BRESP      <= OKAY;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (wState == W_RESP) begin
      if (BREADY) begin
        wState  <= W_IDLE;
        BVALID  <= 1'b0;
        AWREADY <= 1'b1;
        WREADY  <= 1'b1;
      end
    end else if (commit) begin
      wState     <= W_RESP;
      awCaptured <= 1'b0;
      wCaptured  <= 1'b0;
      AWREADY    <= 1'b0;
      WREADY     <= 1'b0;
      BVALID     <= 1'b1;
      BRESP      <= wErr ? SLVERR : OKAY;
      if (!wErr) regs[wIdx] <= mergeData;
    end else begin
      awCaptured <= aHave;
      wCaptured  <= dHave;
      AWREADY    <= !aHave;
      WREADY     <= !dHave;
      if (awHs) awAddrQ <= AWADDR;
      if (wHs) begin
        wDataQ <= WDATA;
        wStrbQ <= WSTRB;
      end
    end
  end
  // Reading regs here with the write on the same edge returns the pre-write value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rState  <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= OKAY;
    end else if (rState == R_DATA) begin
      if (RREADY) begin
        rState  <= R_IDLE;
        RVALID  <= 1'b0;
        ARREADY <= 1'b1;
      end
    end else if (ARVALID && ARREADY) begin
      rState  <= R_DATA;
      ARREADY <= 1'b0;
      RVALID  <= 1'b1;
      RDATA   <= rErr ? '0 : regs[rIdx];
      RRESP   <= rErr ? SLVERR : OKAY;
    end else begin
      ARREADY <= 1'b1;
    end
  end
  for (genvar k = 0; k < NUM_REGS; k++) begin : gOut
    assign regOut[32*k +: 32] = regs[k];
  end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs: table-driven AXI4-Lite accesses with response scoreboards plus corner sequences
module tb_axi_lite_slave_regs;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] AWADDR, ARADDR;
  logic AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [31:0] WDATA;
  logic [3:0] WSTRB;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0] BRESP, RRESP;
  logic [31:0] RDATA;
  logic [255:0] regOut;
  int errors = 0;
  int checks = 0;
  logic [33:0] rq[$];
  logic [1:0] bq[$];
  typedef struct {
    bit          isWrite;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] expData;
    logic [1:0]  expResp;
  } vec_t;
  vec_t vecs[12];
  logic [31:0] expRegs[8];

  axi_lite_slave_regs #(.NUM_REGS(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regOut(regOut)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] resp);
    int n = 0;
    logic awGo, wGo;
    logic [1:0] e;
    bq.push_back(resp);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    while ((AWVALID || WVALID) && n < 20) begin
      awGo = AWVALID && AWREADY;
      wGo = WVALID && WREADY;
      @(negedge clk);
      if (awGo) AWVALID = 1'b0;
      if (wGo) WVALID = 1'b0;
      n++;
    end
    chk("wr_handshake_timeout", {31'b0, AWVALID || WVALID}, 32'd0);
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("bvalid_latency", {31'b0, BVALID}, 32'd1);
    if (bq.size() == 0) chk("bq_empty", 32'd1, 32'd0);
    else begin
      e = bq.pop_front();
      chk("bresp", {30'b0, BRESP}, {30'b0, e});
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    chk("bvalid_drop", {31'b0, BVALID}, 32'd0);
  endtask

  task automatic doRead(input logic [7:0] a, input logic [31:0] d, input logic [1:0] resp);
    int n = 0;
    logic [33:0] e;
    rq.push_back({d, resp});
    ARADDR = a; ARVALID = 1'b1;
    while (!ARREADY && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_timeout", {31'b0, ARREADY}, 32'd1);
    @(negedge clk);
    ARVALID = 1'b0;
    chk("rvalid_latency", {31'b0, RVALID}, 32'd1);
    if (rq.size() == 0) chk("rq_empty", 32'd1, 32'd0);
    else begin
      e = rq.pop_front();
      chk("rdata", RDATA, e[33:2]);
      chk("rresp", {30'b0, RRESP}, {30'b0, e[1:0]});
    end
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
    chk("rvalid_drop", {31'b0, RVALID}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h0,        2'b00};
    vecs[1]  = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
    vecs[2]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
    vecs[3]  = '{1'b1, 8'h08, 32'hCAFEF00D, 4'h3, 32'h0,        2'b00};
    vecs[4]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'h0000F00D, 2'b00};
    vecs[5]  = '{1'b1, 8'h0C, 32'h12345678, 4'h0, 32'h0,        2'b00};
    vecs[6]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h0,        2'b00};
    vecs[7]  = '{1'b1, 8'h1F, 32'hA5A5A5A5, 4'h8, 32'h0,        2'b00};
    vecs[8]  = '{1'b0, 8'h1C, 32'h0,        4'h0, 32'hA5000000, 2'b00};
`ifdef AXIL_ADDR_DECODE_ERR_EN
    vecs[9]  = '{1'b1, 8'h40, 32'h55AA55AA, 4'hF, 32'h0,        2'b10};
    vecs[10] = '{1'b0, 8'h40, 32'h0,        4'h0, 32'h0,        2'b10};
    vecs[11] = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h0,        2'b00};
    expRegs = '{32'h0, 32'hDEADBEEF, 32'h0000F00D, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5000000};
`else
    vecs[9]  = '{1'b1, 8'h40, 32'h55AA55AA, 4'hF, 32'h0,        2'b00};
    vecs[10] = '{1'b0, 8'h40, 32'h0,        4'h0, 32'h55AA55AA, 2'b00};
    vecs[11] = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h55AA55AA, 2'b00};
    expRegs = '{32'h55AA55AA, 32'hDEADBEEF, 32'h0000F00D, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5000000};
`endif
    rst = 1'b0;
    AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", {31'b0, AWREADY}, 32'd0);
    chk("rst_wready", {31'b0, WREADY}, 32'd0);
    chk("rst_arready", {31'b0, ARREADY}, 32'd0);
    chk("rst_bvalid", {31'b0, BVALID}, 32'd0);
    chk("rst_rvalid", {31'b0, RVALID}, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_regout", {31'b0, regOut != '0}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].isWrite) doWrite(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].expResp);
      else doRead(vecs[i].addr, vecs[i].expData, vecs[i].expResp);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("regout_%0d", i), regOut[32*i +: 32], expRegs[i]);

    // W first, AW three cycles later, then B back-pressure
    WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1;
    @(negedge clk);
    WVALID = 1'b0;
    chk("wfirst_no_bvalid", {31'b0, BVALID}, 32'd0);
    repeat (2) @(negedge clk);
    chk("wfirst_wready_low", {31'b0, WREADY}, 32'd0);
    chk("wfirst_awready_high", {31'b0, AWREADY}, 32'd1);
    chk("wfirst_still_no_bvalid", {31'b0, BVALID}, 32'd0);
    AWADDR = 8'h04; AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0;
    chk("aw_late_bvalid", {31'b0, BVALID}, 32'd1);
    chk("aw_late_bresp", {30'b0, BRESP}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bhold_bvalid", {31'b0, BVALID}, 32'd1);
      chk("bhold_bresp", {30'b0, BRESP}, 32'd0);
      chk("bhold_awready", {31'b0, AWREADY}, 32'd0);
      chk("bhold_wready", {31'b0, WREADY}, 32'd0);
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    chk("bhs_bvalid_drop", {31'b0, BVALID}, 32'd0);
    chk("bhs_awready_back", {31'b0, AWREADY}, 32'd1);
    chk("bhs_wready_back", {31'b0, WREADY}, 32'd1);
    chk("strb_merge_reg1", regOut[63:32], 32'hDE22BE44);

    // R back-pressure: RDATA and RVALID hold, ARREADY stays low
    ARADDR = 8'h04; ARVALID = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rhold_rvalid", {31'b0, RVALID}, 32'd1);
      chk("rhold_rdata", RDATA, 32'hDE22BE44);
      chk("rhold_arready", {31'b0, ARREADY}, 32'd0);
    end
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
    chk("rhs_rvalid_drop", {31'b0, RVALID}, 32'd0);
    chk("rhs_arready_back", {31'b0, ARREADY}, 32'd1);

    // Same-edge write commit and read of reg5: read sees the old value
    AWADDR = 8'h14; WDATA = 32'h77777777; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 8'h14; ARVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("coll_bvalid", {31'b0, BVALID}, 32'd1);
    chk("coll_rvalid", {31'b0, RVALID}, 32'd1);
    chk("coll_rdata_old", RDATA, 32'h0);
    RREADY = 1'b1; BREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0; BREADY = 1'b0;
    chk("coll_regout5", regOut[191:160], 32'h77777777);
    doRead(8'h14, 32'h77777777, 2'b00);

    // Asynchronous reset with RVALID high and a W captured
    ARADDR = 8'h04; ARVALID = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0;
    WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge clk);
    WVALID = 1'b0;
    chk("pre_rst_rvalid", {31'b0, RVALID}, 32'd1);
    chk("pre_rst_wready", {31'b0, WREADY}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_rvalid", {31'b0, RVALID}, 32'd0);
    chk("arst_bvalid", {31'b0, BVALID}, 32'd0);
    chk("arst_arready", {31'b0, ARREADY}, 32'd0);
    chk("arst_awready", {31'b0, AWREADY}, 32'd0);
    chk("arst_wready", {31'b0, WREADY}, 32'd0);
    chk("arst_regout", {31'b0, regOut != '0}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    doRead(8'h04, 32'h0, 2'b00);
    doWrite(8'h08, 32'h0BADCAFE, 4'hF, 2'b00);
    doRead(8'h08, 32'h0BADCAFE, 2'b00);
    chk("post_rst_reg1", regOut[63:32], 32'h0);
    chk("post_rst_reg2", regOut[95:64], 32'h0BADCAFE);
    chk("rq_drained", rq.size(), 32'd0);
    chk("bq_drained", bq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
